alu_rs: RTL

ALU_RS -- requirements
Module: alu_rs

---
 rtl/alu_rs.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/alu_rs.sv
// alu_rs: 2^RS_WIDTH-entry ALU reservation station with CDB wakeup and lowest-index dispatch.
// Define ALU_RS_ISSUE_FWD_EN to capture a same-cycle CDB result into an operand being issued.
`ifndef ROB_WIDTH
`define ROB_WIDTH 4
`endif

module alu_rs #(
    parameter int RS_WIDTH = 3
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  clear,
    input  logic                  issue_valid,
    input  logic [4:0]            issue_op,
    input  logic [`ROB_WIDTH-1:0] issue_rob_id,
    input  logic [31:0]           issue_vj,
    input  logic [31:0]           issue_vk,
    input  logic [`ROB_WIDTH-1:0] issue_qj,
    input  logic [`ROB_WIDTH-1:0] issue_qk,
    input  logic                  issue_rj,
    input  logic                  issue_rk,
    input  logic [31:0]           issue_true_jaddr,
    input  logic [31:0]           issue_false_jaddr,
    output logic                  full,
    input  logic                  alu_ready,
    input  logic [`ROB_WIDTH-1:0] alu_rob_id,
    input  logic [31:0]           alu_value,
    input  logic                  lsb_ready,
    input  logic [`ROB_WIDTH-1:0] lsb_rob_id,
    input  logic [31:0]           lsb_value,
    output logic                  calc_enable,
    output logic [31:0]           lhs,
    output logic [31:0]           rhs,
    output logic [4:0]            op,
    output logic [`ROB_WIDTH-1:0] rob_dep,
    output logic [31:0]           true_jaddr,
    output logic [31:0]           false_jaddr
);
    localparam int N = 1 << RS_WIDTH;

    logic [N-1:0]            busy_q, busy_d, rj_q, rj_d, rk_q, rk_d;
    logic [4:0]              op_q [N], op_d [N];
    logic [31:0]             vj_q [N], vj_d [N], vk_q [N], vk_d [N];
    logic [31:0]             tj_q [N], tj_d [N], fj_q [N], fj_d [N];
    logic [`ROB_WIDTH-1:0]   qj_q [N], qj_d [N], qk_q [N], qk_d [N], rob_q [N], rob_d [N];
    logic [RS_WIDTH-1:0]     free_idx, disp_idx;
    logic                    disp_found;
    logic                    calc_q, calc_d;
    logic [31:0]             lhs_q, lhs_d, rhs_q, rhs_d, tja_q, tja_d, fja_q, fja_d;
    logic [4:0]              op_out_q, op_out_d;
    logic [`ROB_WIDTH-1:0]   dep_q, dep_d;

    assign full        = &busy_q;
    assign calc_enable = calc_q;
    assign lhs         = lhs_q;
    assign rhs         = rhs_q;
    assign op          = op_out_q;
    assign rob_dep     = dep_q;
    assign true_jaddr  = tja_q;
    assign false_jaddr = fja_q;

    // Descending scan leaves the lowest matching index selected.
    always_comb begin
        free_idx   = '0;
        disp_idx   = '0;
        disp_found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (!busy_q[i]) free_idx = RS_WIDTH'(i);
            if (busy_q[i] && rj_q[i] && rk_q[i]) begin
                disp_idx   = RS_WIDTH'(i);
                disp_found = 1'b1;
            end
        end
    end

    always_comb begin
        busy_d   = busy_q;
        rj_d     = rj_q;
        rk_d     = rk_q;
        op_d     = op_q;
        vj_d     = vj_q;
        vk_d     = vk_q;
        qj_d     = qj_q;
        qk_d     = qk_q;
        rob_d    = rob_q;
        tj_d     = tj_q;
        fj_d     = fj_q;
        calc_d   = calc_q;
        lhs_d    = lhs_q;
        rhs_d    = rhs_q;
        op_out_d = op_out_q;
        dep_d    = dep_q;
        tja_d    = tja_q;
        fja_d    = fja_q;
        if (rdy_in) begin
            for (int i = 0; i < N; i++) begin
                if (busy_q[i] && !rj_q[i] && alu_ready && qj_q[i] == alu_rob_id) begin
                    vj_d[i] = alu_value;
                    rj_d[i] = 1'b1;
                end else if (busy_q[i] && !rj_q[i] && lsb_ready && qj_q[i] == lsb_rob_id) begin
                    vj_d[i] = lsb_value;
                    rj_d[i] = 1'b1;
                end
                if (busy_q[i] && !rk_q[i] && alu_ready && qk_q[i] == alu_rob_id) begin
                    vk_d[i] = alu_value;
                    rk_d[i] = 1'b1;
                end else if (busy_q[i] && !rk_q[i] && lsb_ready && qk_q[i] == lsb_rob_id) begin
                    vk_d[i] = lsb_value;
                    rk_d[i] = 1'b1;
                end
            end
            if (disp_found) busy_d[disp_idx] = 1'b0;
            if (issue_valid && !full) begin
                busy_d[free_idx] = 1'b1;
                op_d[free_idx]   = issue_op;
                rob_d[free_idx]  = issue_rob_id;
                vj_d[free_idx]   = issue_vj;
                vk_d[free_idx]   = issue_vk;
                qj_d[free_idx]   = issue_qj;
                qk_d[free_idx]   = issue_qk;
                rj_d[free_idx]   = issue_rj;
                rk_d[free_idx]   = issue_rk;
                tj_d[free_idx]   = issue_true_jaddr;
                fj_d[free_idx]   = issue_false_jaddr;
`ifdef ALU_RS_ISSUE_FWD_EN
                if (!issue_rj && alu_ready && issue_qj == alu_rob_id) begin
                    vj_d[free_idx] = alu_value;
                    rj_d[free_idx] = 1'b1;
                end else if (!issue_rj && lsb_ready && issue_qj == lsb_rob_id) begin
                    vj_d[free_idx] = lsb_value;
                    rj_d[free_idx] = 1'b1;
                end
                if (!issue_rk && alu_ready && issue_qk == alu_rob_id) begin
                    vk_d[free_idx] = alu_value;
                    rk_d[free_idx] = 1'b1;
                end else if (!issue_rk && lsb_ready && issue_qk == lsb_rob_id) begin
                    vk_d[free_idx] = lsb_value;
                    rk_d[free_idx] = 1'b1;
                end
`endif
            end
            calc_d   = disp_found && !clear;
            lhs_d    = calc_d ? vj_q[disp_idx] : '0;
            rhs_d    = calc_d ? vk_q[disp_idx] : '0;
            op_out_d = calc_d ? op_q[disp_idx] : '0;
            dep_d    = calc_d ? rob_q[disp_idx] : '0;
            tja_d    = calc_d ? tj_q[disp_idx] : '0;
            fja_d    = calc_d ? fj_q[disp_idx] : '0;
            if (clear) busy_d = '0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            busy_q   <= '0;
            calc_q   <= 1'b0;
            lhs_q    <= '0;
            rhs_q    <= '0;
            op_out_q <= '0;
            dep_q    <= '0;
            tja_q    <= '0;
            fja_q    <= '0;
        end else begin
            busy_q   <= busy_d;
            calc_q   <= calc_d;
            lhs_q    <= lhs_d;
            rhs_q    <= rhs_d;
            op_out_q <= op_out_d;
            dep_q    <= dep_d;
            tja_q    <= tja_d;
            fja_q    <= fja_d;
        end
    end

    always_ff @(posedge clk_in) begin
        rj_q  <= rj_d;
        rk_q  <= rk_d;
        op_q  <= op_d;
        vj_q  <= vj_d;
        vk_q  <= vk_d;
        qj_q  <= qj_d;
        qk_q  <= qk_d;
        rob_q <= rob_d;
        tj_q  <= tj_d;
        fj_q  <= fj_d;
    end
endmodule
